// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding,
// relock counter width and a parameter helper.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } pll_state_e;

    localparam int RELOCK_W = 8;

    // Largest of three cycle limits; sizes the shared counters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Asynchronous active-high reset, both stages reset to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor on the free-running refclk: holds the PLL in reset,
// waits for a stable synchronized lock, then releases the system reset.
// Lock loss in RUN re-pulses PLL reset and counts the event (saturating).
// Optional feature macro: PLL_SUP_TIMEOUT_EN -- retries the PLL reset when
// no stable lock is reached within LOCK_TIMEOUT_CYCLES.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked_i,
    input  logic                soft_rst_i,
    output logic                pll_rst_o,
    output logic                sys_rst_o,
    output logic                lock_lost_o,
    output logic [RELOCK_W-1:0] relock_cnt_o,
    output logic [1:0]          state_o
);

    localparam int MAX_LIM = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    logic                locked_s;
    pll_state_e          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                lost;
    logic                pll_rst_n, sys_rst_n, lock_lost_n;
    logic [RELOCK_W-1:0] relock_n;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_i),
        .q   (locked_s)
    );

`ifdef PLL_SUP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo, tmo_n;

    // Timeout counter spans WAIT_LOCK and STABLE; it is zero on each entry
    // to WAIT_LOCK from PLL_RST because it is held clear in every other state.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) tmo <= '0;
        else     tmo <= tmo_n;
    end
`endif

    // State register, shared counter and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state        <= S_PLL_RST;
            cnt          <= '0;
            pll_rst_o    <= 1'b1;
            sys_rst_o    <= 1'b1;
            lock_lost_o  <= 1'b0;
            relock_cnt_o <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pll_rst_o    <= pll_rst_n;
            sys_rst_o    <= sys_rst_n;
            lock_lost_o  <= lock_lost_n;
            relock_cnt_o <= relock_n;
        end
    end

    // Next-state and counter logic; soft reset overrides everything,
    // including a lock loss seen in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lost    = 1'b0;
`ifdef PLL_SUP_TIMEOUT_EN
        tmo_n   = '0;
`endif
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                cnt_n = '0;
                if (locked_s) state_n = S_STABLE;
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_n = S_PLL_RST;
                    cnt_n   = '0;
                    lost    = 1'b1;
                end
            end
            default: begin
                state_n = S_PLL_RST;
                cnt_n   = '0;
            end
        endcase
`ifdef PLL_SUP_TIMEOUT_EN
        if (state == S_WAIT_LOCK || state == S_STABLE) begin
            tmo_n = tmo + 1'b1;
            if (tmo == TMO_LAST) begin
                state_n = S_PLL_RST;
                cnt_n   = '0;
                tmo_n   = '0;
            end
        end
`endif
        if (soft_rst_i) begin
            state_n = S_PLL_RST;
            cnt_n   = '0;
            lost    = 1'b0;
`ifdef PLL_SUP_TIMEOUT_EN
            tmo_n   = '0;
`endif
        end
    end

    // Output decode from the next state so the outputs are registered Moore
    // values that change on the same edge as the state.
    always_comb begin
        pll_rst_n   = (state_n == S_PLL_RST);
        sys_rst_n   = (state_n != S_RUN);
        lock_lost_n = lost;
        relock_n    = relock_cnt_o;
        if (lost && relock_cnt_o != {RELOCK_W{1'b1}})
            relock_n = relock_cnt_o + 1'b1;
    end

    assign state_o = state;

endmodule
